// File: rtl/move_exec.sv
// Move executor: runs a heading settle or a forward move for the maze solver
// and returns a single-cycle mv_cmplt when the motion has finished.
//
// state | meaning
// IDLE  | waiting for strt_hdng / strt_mv, speed held at 0
// HDNG  | speed 0, counting consecutive in-tolerance heading samples
// RAMP  | accelerating toward MAX_SPD, watching for wall or side opening
// DECEL | gentle slow-down after a side opening, completes at speed 0
// HSTOP | hard slow-down for a wall ahead, completes at speed 0
module move_exec #(
    parameter bit          FAST_SIM = 1'b1,
    parameter logic [10:0] MAX_SPD  = 11'h2A0,
    parameter logic [11:0] HDNG_TOL = 12'h030
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_hdng,
    input  logic        strt_mv,
    input  logic        stp_lft,
    input  logic        stp_rght,
    input  logic [11:0] error,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        frwrd_opn,
    output logic [10:0] frwrd_spd,
    output logic        moving,
    output logic        mv_cmplt
);

    localparam logic [10:0] SPD_INC     = FAST_SIM ? 11'h018 : 11'h003;
    localparam logic [10:0] DECEL_STEP  = SPD_INC << 1;
    localparam logic [10:0] HSTOP_STEP  = SPD_INC << 2;
    localparam logic [6:0]  SETTLE_LAST = FAST_SIM ? 7'd3 : 7'd63;

    typedef enum logic [2:0] {IDLE, HDNG, RAMP, DECEL, HSTOP} state_t;

    state_t      state, nxt_state;
    logic [10:0] nxt_spd;
    logic [6:0]  settle_cnt, nxt_settle_cnt;
    logic        prev_lft, prev_rght, nxt_prev_lft, nxt_prev_rght;
    logic        nxt_cmplt;

    logic [11:0] err_mag;
    logic        in_tol;
    logic [11:0] ramp_sum;
    logic [10:0] ramp_spd, decel_spd, hstop_spd;
    logic        side_edge;

    // 12'h800 has no positive counterpart; it stays 12'h800 and fails the compare.
    assign err_mag   = error[11] ? (~error + 12'd1) : error;
    assign in_tol    = (err_mag < HDNG_TOL);

    assign ramp_sum  = {1'b0, frwrd_spd} + {1'b0, SPD_INC};
    assign ramp_spd  = (ramp_sum > {1'b0, MAX_SPD}) ? MAX_SPD : ramp_sum[10:0];
    assign decel_spd = (frwrd_spd < DECEL_STEP) ? 11'd0 : (frwrd_spd - DECEL_STEP);
    assign hstop_spd = (frwrd_spd < HSTOP_STEP) ? 11'd0 : (frwrd_spd - HSTOP_STEP);

    assign side_edge = (stp_lft  & lft_opn  & ~prev_lft) |
                       (stp_rght & rght_opn & ~prev_rght);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frwrd_spd  <= 11'd0;
            settle_cnt <= 7'd0;
            prev_lft   <= 1'b0;
            prev_rght  <= 1'b0;
            mv_cmplt   <= 1'b0;
        end else begin
            state      <= nxt_state;
            frwrd_spd  <= nxt_spd;
            settle_cnt <= nxt_settle_cnt;
            prev_lft   <= nxt_prev_lft;
            prev_rght  <= nxt_prev_rght;
            mv_cmplt   <= nxt_cmplt;
        end
    end

    always_comb begin
        nxt_state      = state;
        nxt_spd        = frwrd_spd;
        nxt_settle_cnt = settle_cnt;
        nxt_prev_lft   = prev_lft;
        nxt_prev_rght  = prev_rght;
        nxt_cmplt      = 1'b0;
        case (state)
            IDLE: begin
                nxt_spd = 11'd0;
                if (strt_hdng) begin
                    nxt_state      = HDNG;
                    nxt_settle_cnt = 7'd0;
                end else if (strt_mv) begin
                    // Capture openings present at start so they cannot stop the move.
                    nxt_state     = RAMP;
                    nxt_prev_lft  = lft_opn;
                    nxt_prev_rght = rght_opn;
                end
            end
            HDNG: begin
                nxt_spd = 11'd0;
                if (in_tol) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        nxt_cmplt      = 1'b1;
                        nxt_state      = IDLE;
                        nxt_settle_cnt = 7'd0;
                    end else begin
                        nxt_settle_cnt = settle_cnt + 7'd1;
                    end
                end else begin
                    nxt_settle_cnt = 7'd0;
                end
            end
            RAMP: begin
                nxt_spd       = ramp_spd;
                nxt_prev_lft  = lft_opn;
                nxt_prev_rght = rght_opn;
                if (!frwrd_opn)
                    nxt_state = HSTOP;
                else if (side_edge)
                    nxt_state = DECEL;
            end
            DECEL: begin
                if (frwrd_spd == 11'd0) begin
                    nxt_cmplt = 1'b1;
                    nxt_state = IDLE;
                end else begin
                    nxt_spd = decel_spd;
                    if (!frwrd_opn)
                        nxt_state = HSTOP;
                end
            end
            HSTOP: begin
                if (frwrd_spd == 11'd0) begin
                    nxt_cmplt = 1'b1;
                    nxt_state = IDLE;
                end else begin
                    nxt_spd = hstop_spd;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        moving = (state != IDLE);
    end

endmodule

// File: tb/tb_move_exec.sv
// Directed bench for move_exec (FAST_SIM=1): a vector table for heading
// settle and arbitration, followed by hand sequences for the forward moves.
module tb_move_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght;
    logic [11:0] error;
    logic        lft_opn, rght_opn, frwrd_opn;
    logic [10:0] frwrd_spd;
    logic        moving, mv_cmplt;

    int checks = 0;
    int errors = 0;

    move_exec #(.FAST_SIM(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .error     (error),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .frwrd_spd (frwrd_spd),
        .moving    (moving),
        .mv_cmplt  (mv_cmplt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hdng;
        logic        mv;
        logic [11:0] err;
        logic        mov;
        logic        cmp;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic h, input logic m, input logic [11:0] e,
                                input logic mov, input logic cmp);
        vec_t v;
        v.hdng = h; v.mv = m; v.err = e; v.mov = mov; v.cmp = cmp;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [10:0] spd, input logic mov, input logic cmp);
        chk({nm, " frwrd_spd"}, {21'd0, frwrd_spd}, {21'd0, spd});
        chk({nm, " moving"},    {31'd0, moving},    {31'd0, mov});
        chk({nm, " mv_cmplt"},  {31'd0, mv_cmplt},  {31'd0, cmp});
    endtask

    task automatic pulse_mv();
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
    endtask

    function automatic logic [10:0] ramp_exp(input int k);
        int s;
        s = k * 24;
        if (s > 672) s = 672;
        return 11'(s);
    endfunction

    initial begin
        // settle sequence, restart on 12'hF00, tolerance boundaries, arbitration
        tbl[0]  = mk(1, 0, 12'h010, 1, 0);
        tbl[1]  = mk(0, 0, 12'h010, 1, 0);
        tbl[2]  = mk(0, 0, 12'h010, 1, 0);
        tbl[3]  = mk(0, 0, 12'h010, 1, 0);
        tbl[4]  = mk(0, 0, 12'h010, 0, 1);
        tbl[5]  = mk(0, 0, 12'h010, 0, 0);
        tbl[6]  = mk(1, 0, 12'h010, 1, 0);
        tbl[7]  = mk(0, 0, 12'h010, 1, 0);
        tbl[8]  = mk(0, 0, 12'h010, 1, 0);
        tbl[9]  = mk(0, 0, 12'hF00, 1, 0);
        tbl[10] = mk(0, 0, 12'h010, 1, 0);
        tbl[11] = mk(0, 0, 12'h010, 1, 0);
        tbl[12] = mk(0, 0, 12'h010, 1, 0);
        tbl[13] = mk(0, 0, 12'h010, 0, 1);
        tbl[14] = mk(1, 1, 12'h02F, 1, 0);
        tbl[15] = mk(0, 0, 12'h030, 1, 0);
        tbl[16] = mk(0, 0, 12'hFD1, 1, 0);
        tbl[17] = mk(0, 1, 12'h02F, 1, 0);
        tbl[18] = mk(0, 0, 12'h800, 1, 0);
        tbl[19] = mk(0, 0, 12'hFD0, 1, 0);
        tbl[20] = mk(0, 0, 12'h02F, 1, 0);
        tbl[21] = mk(0, 0, 12'h02F, 1, 0);
        tbl[22] = mk(0, 0, 12'h02F, 1, 0);
        tbl[23] = mk(0, 0, 12'h02F, 0, 1);
        tbl[24] = mk(0, 0, 12'h02F, 0, 0);

        rst = 1'b1; strt_hdng = 1'b0; strt_mv = 1'b0; stp_lft = 1'b0; stp_rght = 1'b0;
        error = 12'h000; lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b1;
        tick();
        tick();
        chk_out("reset", 11'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("idle", 11'd0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            strt_hdng = tbl[i].hdng;
            strt_mv   = tbl[i].mv;
            error     = tbl[i].err;
            tick();
            strt_hdng = 1'b0;
            strt_mv   = 1'b0;
            chk_out($sformatf("vec%0d", i), 11'd0, tbl[i].mov, tbl[i].cmp);
        end
        error = 12'h000;

        // ramp with left opening present at start, then left-side stop
        stp_lft = 1'b1; lft_opn = 1'b1;
        pulse_mv();
        chk_out("a_start", 11'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk_out($sformatf("a_ramp%0d", k), ramp_exp(k), 1'b1, 1'b0);
        end
        lft_opn = 1'b0;
        tick();
        chk_out("a_lft_fall", 11'h2A0, 1'b1, 1'b0);
        lft_opn = 1'b1;
        tick();
        chk_out("a_lft_rise", 11'h2A0, 1'b1, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk_out($sformatf("a_decel%0d", k), 11'(672 - 48 * k), 1'b1, 1'b0);
        end
        tick();
        chk_out("a_done", 11'd0, 1'b0, 1'b1);
        tick();
        chk_out("a_after", 11'd0, 1'b0, 1'b0);
        stp_lft = 1'b0; lft_opn = 1'b0;

        // wall stop from full speed; unselected left edge must not stop the move
        stp_rght = 1'b1; rght_opn = 1'b1;
        pulse_mv();
        chk_out("b_start", 11'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) lft_opn = 1'b1;
            tick();
            chk_out($sformatf("b_ramp%0d", k), ramp_exp(k), 1'b1, 1'b0);
        end
        frwrd_opn = 1'b0;
        tick();
        chk_out("b_wall", 11'h2A0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_out($sformatf("b_hstop%0d", k), 11'(672 - 96 * k), 1'b1, 1'b0);
        end
        tick();
        chk_out("b_done", 11'd0, 1'b0, 1'b1);
        frwrd_opn = 1'b1;
        tick();
        chk_out("b_after", 11'd0, 1'b0, 1'b0);
        stp_rght = 1'b0; rght_opn = 1'b0; lft_opn = 1'b0;

        // right-side stop, then wall during DECEL promotes to HSTOP
        stp_rght = 1'b1;
        pulse_mv();
        chk_out("c_start", 11'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_out($sformatf("c_ramp%0d", k), ramp_exp(k), 1'b1, 1'b0);
        end
        rght_opn = 1'b1;
        tick();
        chk_out("c_rght_rise", 11'h108, 1'b1, 1'b0);
        tick();
        chk_out("c_decel", 11'h0D8, 1'b1, 1'b0);
        frwrd_opn = 1'b0;
        tick();
        chk_out("c_promote", 11'h0A8, 1'b1, 1'b0);
        tick();
        chk_out("c_hstop1", 11'h048, 1'b1, 1'b0);
        tick();
        chk_out("c_hstop_floor", 11'h000, 1'b1, 1'b0);
        tick();
        chk_out("c_done", 11'd0, 1'b0, 1'b1);
        frwrd_opn = 1'b1; stp_rght = 1'b0; rght_opn = 1'b0;
        tick();
        chk_out("c_after", 11'd0, 1'b0, 1'b0);

        // reset in the middle of a ramp
        pulse_mv();
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk_out($sformatf("d_ramp%0d", k), ramp_exp(k), 1'b1, 1'b0);
        end
        rst = 1'b1;
        tick();
        chk_out("d_rst", 11'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("d_post%0d", k), 11'd0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
